round_timer_ctrl: RTL and testbench

Sequencer that turns the free-running one-second `timeout` pulse of the interval timer into a controllable countdown for a game round. It loads a seconds preset, holds the interval timer in reset whenever the countdown is not running, and counts ticks down to zero. It supports pause, resume, abort and restart, and reports remaining seconds, a low-time warning and a one-cycle expiry pulse to the game FSM and display logic.

---
 rtl/round_timer_ctrl.sv | 112 +++++++++++
 tb/tb_round_timer_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/round_timer_ctrl.sv
// Round countdown sequencer: loads a seconds preset, gates the interval timer, counts its ticks down to zero.
// All outputs registered, one cycle after the sampled command/tick; no backpressure, commands are single-cycle pulses.
module round_timer_ctrl #(
  parameter int SECS_W    = 8,
  parameter int MAX_SECS  = 255,
  parameter int WARN_SECS = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              pause,
  input  logic              resume,
  input  logic              abort,
  input  logic [SECS_W-1:0] load_secs,
  input  logic              tick,
  output logic              timer_reset_n,
  output logic [SECS_W-1:0] remaining,
  output logic              busy,
  output logic              paused,
  output logic              warn,
  output logic              expired,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [SECS_W-1:0] MAX_V  = SECS_W'(MAX_SECS);
  localparam logic [SECS_W-1:0] WARN_V = SECS_W'(WARN_SECS);
  localparam logic [SECS_W-1:0] ONE_V  = SECS_W'(1);

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [SECS_W-1:0] rem_nx;
  logic [SECS_W-1:0] preset;
  logic              exp_nx;
  logic              start_acc;
  logic              busy_nx;

  always_comb begin
    preset = (load_secs > MAX_V) ? MAX_V : load_secs;
  end

  always_comb begin
    state_nx  = state;
    rem_nx    = remaining;
    exp_nx    = 1'b0;
    start_acc = 1'b0;
    if (abort) begin
      state_nx = S_IDLE;
      rem_nx   = '0;
    end else if (start) begin
      // A start always restarts the interval timer, even when already running.
      start_acc = 1'b1;
      if (preset == '0) begin
        state_nx = S_DONE;
        rem_nx   = '0;
        exp_nx   = 1'b1;
      end else begin
        state_nx = S_RUN;
        rem_nx   = preset;
      end
    end else begin
      case (state)
        S_RUN: begin
          if (tick && (remaining <= ONE_V)) begin
            state_nx = S_DONE;
            rem_nx   = '0;
            exp_nx   = 1'b1;
          end else begin
            if (tick) rem_nx = remaining - ONE_V;
            if (pause) state_nx = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (resume) state_nx = S_RUN;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    busy_nx = (state_nx == S_RUN) || (state_nx == S_PAUSE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      remaining     <= '0;
      expired       <= 1'b0;
      timer_reset_n <= 1'b0;
      busy          <= 1'b0;
      paused        <= 1'b0;
      warn          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nx;
      remaining     <= rem_nx;
      expired       <= exp_nx;
      timer_reset_n <= (state_nx == S_RUN) && !start_acc;
      busy          <= busy_nx;
      paused        <= (state_nx == S_PAUSE);
      warn          <= busy_nx && (rem_nx != '0) && (rem_nx <= WARN_V);
      done          <= (state_nx == S_DONE);
    end
  end

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Bench for round_timer_ctrl: directed commands, per-cycle compare against a flag-based round model,
// plus literal checkpoints. MAX_SECS is 250 so the clamp is reachable with an 8-bit preset.
module tb_round_timer_ctrl;
  localparam int SW   = 8;
  localparam int MAXS = 250;
  localparam int WARN = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0, pause = 1'b0, resume = 1'b0, abort = 1'b0, tick = 1'b0;
  logic [SW-1:0] load_secs = '0;
  logic          timer_reset_n, busy, paused, warn, expired, done;
  logic [SW-1:0] remaining;

  int total = 0;
  int passes = 0;

  round_timer_ctrl #(.SECS_W(SW), .MAX_SECS(MAXS), .WARN_SECS(WARN)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .resume(resume),
    .abort(abort), .load_secs(load_secs), .tick(tick), .timer_reset_n(timer_reset_n),
    .remaining(remaining), .busy(busy), .paused(paused), .warn(warn),
    .expired(expired), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Round model: remaining seconds plus running/paused/finished flags.
  int m_rem = 0;
  bit m_run = 0, m_pau = 0, m_fin = 0, m_exp = 0, m_trst = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rem = 0; m_run = 0; m_pau = 0; m_fin = 0; m_exp = 0; m_trst = 0;
    end else begin
      bit restarted;
      int ld;
      restarted = 0;
      m_exp = 0;
      if (abort) begin
        m_rem = 0; m_run = 0; m_pau = 0; m_fin = 0;
      end else if (start) begin
        restarted = 1;
        ld = (int'(load_secs) > MAXS) ? MAXS : int'(load_secs);
        m_rem = ld; m_pau = 0;
        m_run = (ld != 0); m_fin = (ld == 0); m_exp = (ld == 0);
      end else if (m_run) begin
        if (tick) m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_run = 0; m_fin = 1; m_exp = 1;
        end else if (pause) begin
          m_run = 0; m_pau = 1;
        end
      end else if (m_pau && resume) begin
        m_pau = 0; m_run = 1;
      end
      m_trst = m_run && !restarted;
    end
  end

  always @(negedge clk) begin
    chk("remaining", int'(remaining), m_rem);
    chk("busy", int'(busy), int'(m_run || m_pau));
    chk("paused", int'(paused), int'(m_pau));
    chk("done", int'(done), int'(m_fin));
    chk("expired", int'(expired), int'(m_exp));
    chk("timer_reset_n", int'(timer_reset_n), int'(m_trst));
    chk("warn", int'(warn), int'((m_run || m_pau) && m_rem > 0 && m_rem <= WARN));
  end

  // Drive one cycle of inputs starting at posedge+1; returns at the next posedge+1.
  task automatic cyc(input bit s, input bit p, input bit r, input bit a, input bit t,
                     input int ld);
    start = s; pause = p; resume = r; abort = a; tick = t; load_secs = SW'(ld);
    @(posedge clk); #1;
    start = 0; pause = 0; resume = 0; abort = 0; tick = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Tick preceded by 9 quiet cycles, so ticks are 10 cycles apart.
  task automatic spaced_tick();
    idle(9);
    cyc(0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    idle(3);
    chk("rst_remaining", int'(remaining), 0);
    chk("rst_trst", int'(timer_reset_n), 0);
    chk("rst_busy_done", int'({busy, done, warn, expired}), 0);
    reset_n = 1'b1;
    idle(2);

    // Basic countdown of 3.
    cyc(1, 0, 0, 0, 0, 3);
    chk("t1_load", int'(remaining), 3);
    chk("t1_trst_low_first", int'(timer_reset_n), 0);
    idle(1);
    chk("t1_trst_high", int'(timer_reset_n), 1);
    spaced_tick(); chk("t1_rem2", int'(remaining), 2);
    spaced_tick(); chk("t1_rem1", int'(remaining), 1);
    spaced_tick();
    chk("t1_expired", int'(expired), 1);
    chk("t1_rem0", int'(remaining), 0);
    idle(1);
    chk("t1_exp_one_cycle", int'(expired), 0);
    chk("t1_done_hold", int'(done), 1);
    chk("t1_trst_done", int'(timer_reset_n), 0);

    // Pause/resume, ticks ignored while paused.
    cyc(1, 0, 0, 0, 0, 5);
    spaced_tick(); chk("t2_rem4", int'(remaining), 4);
    cyc(0, 1, 0, 0, 0, 0);
    chk("t2_paused", int'(paused), 1);
    chk("t2_trst_paused", int'(timer_reset_n), 0);
    repeat (4) spaced_tick();
    chk("t2_hold4", int'(remaining), 4);
    cyc(0, 0, 1, 0, 0, 0);
    chk("t2_resumed", int'({busy, paused}), 2);
    repeat (3) spaced_tick();
    chk("t2_rem1", int'(remaining), 1);
    spaced_tick();
    chk("t2_expired", int'({expired, done}), 3);

    // Warning window from 200 down.
    cyc(1, 0, 0, 0, 0, 200);
    for (int i = 0; i < 200; i++) begin
      cyc(0, 0, 0, 0, 1, 0);
      if (remaining == 11) chk("t3_warn_at11", int'(warn), 0);
      if (remaining == 10) chk("t3_warn_at10", int'(warn), 1);
      if (remaining == 1)  chk("t3_warn_at1", int'(warn), 1);
      idle(1);
    end
    chk("t3_done_nowarn", int'({done, warn}), 2);

    // Zero preset and clamp.
    cyc(1, 0, 0, 0, 0, 0);
    chk("t4_zero_exp", int'({expired, done, busy}), 6);
    cyc(1, 0, 0, 0, 0, 255);
    chk("t4_clamp", int'(remaining), 250);
    cyc(1, 0, 0, 0, 0, 250);
    chk("t4_at_max", int'(remaining), 250);
    cyc(0, 0, 0, 1, 0, 0);
    chk("t4_abort", int'({busy, done, remaining}), 0);

    // Restart with coincident tick.
    cyc(1, 0, 0, 0, 0, 8);
    idle(2);
    cyc(0, 0, 0, 0, 1, 0);
    chk("t5_rem7", int'(remaining), 7);
    idle(2);
    cyc(1, 0, 0, 0, 1, 9);
    chk("t5_reload", int'(remaining), 9);
    chk("t5_trst_pulse", int'(timer_reset_n), 0);
    idle(1);
    chk("t5_tick_dropped", int'(remaining), 9);
    chk("t5_trst_back", int'(timer_reset_n), 1);

    // Abort beats start; no-op commands in IDLE.
    cyc(1, 0, 0, 1, 0, 20);
    chk("t6_abort_start", int'({busy, remaining}), 0);
    cyc(0, 1, 1, 0, 1, 0);
    chk("t6_idle_noop", int'({busy, paused, remaining}), 0);

    // Resume while running is a no-op; pause+tick reaching zero goes DONE.
    cyc(1, 0, 0, 0, 0, 2);
    cyc(0, 0, 1, 0, 1, 0);
    chk("t7_resume_noop", int'({busy, paused, remaining}), 'h201);
    cyc(0, 1, 0, 0, 1, 0);
    chk("t7_zero_beats_pause", int'({done, paused, expired}), 5);
    cyc(0, 1, 1, 0, 1, 0);
    chk("t7_done_noop", int'({done, busy}), 2);

    // Asynchronous reset mid-count.
    cyc(1, 0, 0, 0, 0, 6);
    idle(2);
    #2 reset_n = 1'b0;
    #1;
    chk("t8_async_rem", int'(remaining), 0);
    chk("t8_async_lvls", int'({busy, paused, done, warn, expired, timer_reset_n}), 0);
    idle(2);
    reset_n = 1'b1;
    idle(3);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
